// File: rtl/conv_window_buffer.sv
// Sliding KxK window generator for a raster pixel stream.
// Line buffers feed the right-hand window column; the window flops drive window_data directly.
module conv_window_buffer #(
   parameter int KERNEL_SIZE = 5,
   parameter int DATA_WIDTH  = 16,
   parameter int IMG_WIDTH   = 28,
   parameter int IMG_HEIGHT  = 28
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic [DATA_WIDTH-1:0]                         pixel_in,
   input  logic                                          pixel_valid,
   output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_data,
   output logic                                          window_valid,
   output logic [$clog2(IMG_HEIGHT)-1:0]                 out_row,
   output logic [$clog2(IMG_WIDTH)-1:0]                  out_col,
   output logic                                          frame_done
);

   localparam int K  = KERNEL_SIZE;
   localparam int DW = DATA_WIDTH;
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int CW = $clog2(IMG_WIDTH);

   typedef enum logic [1:0] {FILL, STREAM, DONE} state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   col_q, col_d;
   logic [DW-1:0]   win_q [K*K];
   logic [DW-1:0]   win_d [K*K];
   logic            valid_q, valid_d;
   logic [RW-1:0]   out_row_q, out_row_d;
   logic [CW-1:0]   out_col_q, out_col_d;
   logic            done_q, done_d;

   logic [DW-1:0]   lb_mem [K-1][IMG_WIDTH];
   logic [DW-1:0]   tap [K];
   logic            last_col;

   // Vertical taps: oldest row first, the live pixel last.
   always_comb begin
      for (int r = 0; r < K-1; r++) tap[r] = lb_mem[r][col_q];
      tap[K-1] = pixel_in;
   end

   assign last_col = (col_q == CW'(IMG_WIDTH-1));

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      win_d     = win_q;
      valid_d   = 1'b0;
      out_row_d = out_row_q;
      out_col_d = out_col_q;
      done_d    = 1'b0;
      if (pixel_valid) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K-1; c++) win_d[r*K+c] = win_q[r*K+c+1];
            win_d[r*K+K-1] = tap[r];
         end
         if (row_q >= RW'(K-1) && col_q >= CW'(K-1)) begin
            valid_d   = 1'b1;
            out_row_d = row_q - RW'(K-1);
            out_col_d = col_q - CW'(K-1);
         end
         if (last_col) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         unique case (state_q)
            STREAM: begin
               if (last_col && row_q == RW'(IMG_HEIGHT-1)) begin
                  state_d = DONE;
                  row_d   = '0;
                  col_d   = '0;
                  done_d  = 1'b1;
               end
            end
            default: begin
               // DONE accepts pixel (0,0) of the next frame like FILL does
               if (last_col && row_q == RW'(K-2)) state_d = STREAM;
               else                               state_d = FILL;
            end
         endcase
      end else if (state_q == DONE) begin
         state_d = FILL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FILL;
         row_q     <= '0;
         col_q     <= '0;
         win_q     <= '{default: '0};
         valid_q   <= 1'b0;
         out_row_q <= '0;
         out_col_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         win_q     <= win_d;
         valid_q   <= valid_d;
         out_row_q <= out_row_d;
         out_col_q <= out_col_d;
         done_q    <= done_d;
      end
   end

   // Storage only, never reset; each column slot rotates up one row.
   always_ff @(posedge clk) begin
      if (pixel_valid && !reset) begin
         for (int r = 0; r < K-2; r++) lb_mem[r][col_q] <= lb_mem[r+1][col_q];
         lb_mem[K-2][col_q] <= pixel_in;
      end
   end

   always_comb begin
      for (int i = 0; i < K*K; i++) window_data[i*DW +: DW] = win_q[i];
   end

   assign window_valid = valid_q;
   assign out_row      = out_row_q;
   assign out_col      = out_col_q;
   assign frame_done   = done_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Bench for conv_window_buffer: scoreboard of expected windows built from pixel coordinates.
// A second small instance (K=3, 6x6) covers the reduced-size case.
module tb_conv_window_buffer;

   localparam int K  = 5;
   localparam int DW = 16;
   localparam int W  = 28;
   localparam int H  = 28;
   localparam int WB = K*K*DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          pixel_valid;
   logic [DW-1:0] pixel_in;
   logic [WB-1:0] window_data;
   logic          window_valid;
   logic [4:0]    out_row;
   logic [4:0]    out_col;
   logic          frame_done;

   logic          reset3;
   logic          pv3;
   logic [15:0]   pin3;
   logic [143:0]  wd3;
   logic          wv3;
   logic [2:0]    orow3;
   logic [2:0]    ocol3;
   logic          fd3;

   always #5 clk = ~clk;

   conv_window_buffer dut (
      .clk(clk), .reset(reset), .pixel_in(pixel_in),
      .pixel_valid(pixel_valid), .window_data(window_data),
      .window_valid(window_valid), .out_row(out_row),
      .out_col(out_col), .frame_done(frame_done)
   );

   conv_window_buffer #(
      .KERNEL_SIZE(3), .DATA_WIDTH(16), .IMG_WIDTH(6), .IMG_HEIGHT(6)
   ) dut3 (
      .clk(clk), .reset(reset3), .pixel_in(pin3),
      .pixel_valid(pv3), .window_data(wd3),
      .window_valid(wv3), .out_row(orow3),
      .out_col(ocol3), .frame_done(fd3)
   );

   typedef struct packed {
      logic [WB-1:0] data;
      logic [4:0]    r;
      logic [4:0]    c;
      logic          last;
   } exp_t;

   exp_t exp_q[$];
   int   fd_t[$];
   int   checks = 0;
   int   failures = 0;
   int   n_win = 0;
   int   n_fd = 0;
   int   cyc = 0;
   bit   pv_last = 1'b0;
   bit   ones_mode = 1'b0;

   function automatic logic [DW-1:0] pix(int tag, bit ones, int idx);
      logic [7:0] hi;
      logic [7:0] lo;
      hi = idx[7:0];
      lo = tag[7:0];
      return ones ? 16'h0100 : {hi, lo};
   endfunction

   function automatic logic [WB-1:0] win_model(int tag, bit ones, int r, int c);
      logic [WB-1:0] w;
      w = '0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            w[(i*K+j)*DW +: DW] = pix(tag, ones, (r-K+1+i)*W + (c-K+1+j));
      return w;
   endfunction

   always @(posedge clk) cyc++;

   // Scoreboard consumer
   always @(negedge clk) begin
      exp_t e;
      int   acc;
      if (window_valid) begin
         n_win++;
         checks++;
         if (!pv_last) begin
            failures++;
            $display("FAIL valid_after_idle: window_valid=1 required 0 at cycle %0d", cyc);
         end
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_window: got row=%0d col=%0d required no window", out_row, out_col);
         end else begin
            e = exp_q.pop_front();
            if ({window_data, out_row, out_col, frame_done} !== {e.data, e.r, e.c, e.last}) begin
               failures++;
               $display("FAIL window: got r=%0d c=%0d fd=%0b data=%h required r=%0d c=%0d fd=%0b data=%h",
                        out_row, out_col, frame_done, window_data, e.r, e.c, e.last, e.data);
            end
         end
         if (ones_mode) begin
            acc = 0;
            for (int i = 0; i < K*K; i++)
               acc += ($signed(window_data[i*DW +: DW]) * 256) >>> 8;
            checks++;
            if (acc !== 32'h1900) begin
               failures++;
               $display("FAIL ones_sum: got %h required 00001900", acc);
            end
         end
      end else begin
         checks++;
         if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL done_without_window: frame_done=%b required 0", frame_done);
         end
      end
      if (frame_done === 1'b1) begin
         n_fd++;
         fd_t.push_back(cyc);
      end
      pv_last = pixel_valid && !reset;
   end

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk); #1;
         pixel_valid = 1'b0;
      end
   endtask

   task automatic feed_frame(int tag, bit ones, bit gaps, int npix);
      int r;
      int c;
      for (int idx = 0; idx < npix; idx++) begin
         r = idx / W;
         c = idx % W;
         @(posedge clk); #1;
         pixel_valid = 1'b1;
         pixel_in    = pix(tag, ones, idx);
         if (r >= K-1 && c >= K-1)
            exp_q.push_back('{data: win_model(tag, ones, r, c),
                              r: 5'(r-K+1), c: 5'(c-K+1),
                              last: (idx == W*H-1)});
         if (gaps) begin
            @(posedge clk); #1;
            pixel_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; pixel_valid = 1'b0; pixel_in = '0;
      reset3 = 1'b1; pv3 = 1'b0; pin3 = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (window_data !== '0) begin failures++; $display("FAIL rst_data: got %h required 0", window_data); end
      checks++; if (window_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b required 0", window_valid); end
      checks++; if (out_row !== 5'd0) begin failures++; $display("FAIL rst_row: got %0d required 0", out_row); end
      checks++; if (out_col !== 5'd0) begin failures++; $display("FAIL rst_col: got %0d required 0", out_col); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b required 0", frame_done); end
      reset = 1'b0;
      reset3 = 1'b0;
   endtask

   task automatic test_stream();
      int w0 = n_win;
      int f0 = n_fd;
      feed_frame(0, 1'b0, 1'b0, W*H);
      idle(4);
      checks++; if (n_win - w0 != 576) begin failures++; $display("FAIL stream_count: got %0d required 576", n_win - w0); end
      checks++; if (n_fd - f0 != 1) begin failures++; $display("FAIL stream_done: got %0d required 1", n_fd - f0); end
   endtask

   task automatic test_gaps();
      int w0 = n_win;
      int f0 = n_fd;
      feed_frame(2, 1'b0, 1'b1, W*H);
      idle(4);
      checks++; if (n_win - w0 != 576) begin failures++; $display("FAIL gaps_count: got %0d required 576", n_win - w0); end
      checks++; if (n_fd - f0 != 1) begin failures++; $display("FAIL gaps_done: got %0d required 1", n_fd - f0); end
   endtask

   task automatic test_mid_reset();
      int w0;
      int f0;
      feed_frame(3, 1'b0, 1'b0, 301);
      @(posedge clk); #1;
      reset = 1'b1;
      pixel_valid = 1'b1;
      pixel_in = pix(3, 1'b0, 301);
      @(posedge clk); #1;
      checks++; if (window_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b required 0", window_valid); end
      pixel_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL mid_rst_pending: got %0d required 0", exp_q.size()); end
      w0 = n_win;
      f0 = n_fd;
      feed_frame(4, 1'b0, 1'b0, W*H);
      idle(4);
      checks++; if (n_win - w0 != 576) begin failures++; $display("FAIL mid_rst_count: got %0d required 576", n_win - w0); end
      checks++; if (n_fd - f0 != 1) begin failures++; $display("FAIL mid_rst_done: got %0d required 1", n_fd - f0); end
   endtask

   task automatic test_back_to_back();
      int w0 = n_win;
      int f0 = n_fd;
      int gap;
      feed_frame(5, 1'b0, 1'b0, W*H);
      feed_frame(6, 1'b0, 1'b0, W*H);
      idle(4);
      checks++; if (n_win - w0 != 1152) begin failures++; $display("FAIL b2b_count: got %0d required 1152", n_win - w0); end
      checks++; if (n_fd - f0 != 2) begin failures++; $display("FAIL b2b_done: got %0d required 2", n_fd - f0); end
      gap = (fd_t.size() >= 2) ? fd_t[fd_t.size()-1] - fd_t[fd_t.size()-2] : -1;
      checks++; if (gap != 784) begin failures++; $display("FAIL b2b_spacing: got %0d required 784", gap); end
   endtask

   task automatic test_all_ones();
      int w0 = n_win;
      ones_mode = 1'b1;
      feed_frame(0, 1'b1, 1'b0, W*H);
      idle(4);
      ones_mode = 1'b0;
      checks++; if (n_win - w0 != 576) begin failures++; $display("FAIL ones_count: got %0d required 576", n_win - w0); end
   endtask

   task automatic test_small_kernel();
      int cnt = 0;
      int fd = 0;
      int ev;
      bit seen = 1'b0;
      for (int i = 0; i <= 40; i++) begin
         @(posedge clk); #1;
         if (wv3) begin
            cnt++;
            if (orow3 == 3'd1 && ocol3 == 3'd2) begin
               seen = 1'b1;
               for (int e = 0; e < 9; e++) begin
                  ev = (e/3 + 1)*6 + (e%3 + 2);
                  checks++;
                  if (wd3[e*16 +: 16] !== 16'(ev)) begin
                     failures++;
                     $display("FAIL k3_elem%0d: got %0d required %0d", e, wd3[e*16 +: 16], ev);
                  end
               end
            end
         end
         if (fd3) fd++;
         pv3  = (i < 36);
         pin3 = 16'(i);
      end
      checks++; if (!seen) begin failures++; $display("FAIL k3_seen: got 0 required 1"); end
      checks++; if (cnt != 16) begin failures++; $display("FAIL k3_count: got %0d required 16", cnt); end
      checks++; if (fd != 1) begin failures++; $display("FAIL k3_done: got %0d required 1", fd); end
   endtask

   initial begin
      reset = 1'b1; pixel_valid = 1'b0; pixel_in = '0;
      reset3 = 1'b1; pv3 = 1'b0; pin3 = '0;
      test_reset();
      test_stream();
      test_gaps();
      test_mid_reset();
      test_back_to_back();
      test_all_ones();
      test_small_kernel();
      idle(2);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover_windows: got %0d required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
